// File: rtl/div2cdb_if.sv
// rtl/div2cdb_if.sv - issue/result bundle between RS, divider FU and CDB arbiter
interface div2cdb_if #(
    parameter int XLEN    = 32,
    parameter int PRF_LEN = 6,
    parameter int ROB_LEN = 5
) ();
    logic               div_enable;
    logic               squash;
    logic [XLEN-1:0]    opa_value;
    logic [XLEN-1:0]    opb_value;
    logic [1:0]         div_func;
    logic [PRF_LEN-1:0] dest_preg_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic [XLEN-1:0]    PC;

    logic [XLEN-1:0]    div_value;
    logic               div_valid;
    logic               div_free;
    logic [PRF_LEN-1:0] div_prf_idx;
    logic [ROB_LEN-1:0] div_rob_idx;
    logic [XLEN-1:0]    div_PC;

    modport master (
        output div_enable, squash, opa_value, opb_value, div_func,
               dest_preg_idx, rob_idx, PC,
        input  div_value, div_valid, div_free, div_prf_idx, div_rob_idx, div_PC
    );

    modport slave (
        input  div_enable, squash, opa_value, opb_value, div_func,
               dest_preg_idx, rob_idx, PC,
        output div_value, div_valid, div_free, div_prf_idx, div_rob_idx, div_PC
    );
endinterface

// File: rtl/div2cdb.sv
// rtl/div2cdb.sv - iterative radix-2 restoring divider FU (DIV/DIVU/REM/REMU) feeding the CDB
module div2cdb #(
    parameter int XLEN    = 32,
    parameter int PRF_LEN = 6,
    parameter int ROB_LEN = 5
) (
    input logic       clock,
    input logic       reset,
    div2cdb_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [XLEN-1:0]    quo;
    logic [XLEN-1:0]    dvsr;
    logic [XLEN:0]      rem;
    logic [CNT_W-1:0]   count;
    logic               is_rem;
    logic               neg_q;
    logic               neg_r;
    logic [PRF_LEN-1:0] pend_prf;
    logic [ROB_LEN-1:0] pend_rob;
    logic [XLEN-1:0]    pend_pc;

    logic [XLEN-1:0]    out_value;
    logic [PRF_LEN-1:0] out_prf;
    logic [ROB_LEN-1:0] out_rob;
    logic [XLEN-1:0]    out_pc;

    logic               free;
    logic               issue;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic               div_zero;
    logic               overflow;
    logic               fast;
    logic [XLEN-1:0]    fast_value;

    logic [XLEN+1:0]    rem_wide;
    logic [XLEN+1:0]    diff;
    logic               take;
    logic [XLEN:0]      rem_next;
    logic [XLEN-1:0]    quo_next;
    logic [XLEN-1:0]    rem_final;
    logic [XLEN-1:0]    final_value;

    assign free  = (state != BUSY);
    assign issue = bus.div_enable && free;

    // Operand decode for the issue cycle
    always_comb begin
        is_signed  = ~bus.div_func[0];
        a_neg      = is_signed & bus.opa_value[XLEN-1];
        b_neg      = is_signed & bus.opb_value[XLEN-1];
        a_mag      = a_neg ? (~bus.opa_value + 1'b1) : bus.opa_value;
        b_mag      = b_neg ? (~bus.opb_value + 1'b1) : bus.opb_value;
        div_zero   = (bus.opb_value == '0);
        overflow   = is_signed && (bus.opa_value == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.opb_value == '1);
        fast       = div_zero || overflow;
        fast_value = '0;
        if (div_zero)
            fast_value = bus.div_func[1] ? bus.opa_value : '1;
        else if (!bus.div_func[1])
            fast_value = bus.opa_value;
    end

    // One restoring step; the top bit of diff is the borrow of the trial subtract
    always_comb begin
        rem_wide    = {rem, quo[XLEN-1]};
        diff        = rem_wide - {2'b00, dvsr};
        take        = ~diff[XLEN+1];
        rem_next    = take ? diff[XLEN:0] : rem_wide[XLEN:0];
        quo_next    = {quo[XLEN-2:0], take};
        rem_final   = rem_next[XLEN-1:0];
        final_value = is_rem ? (neg_r ? (~rem_final + 1'b1) : rem_final)
                             : (neg_q ? (~quo_next + 1'b1) : quo_next);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            quo       <= '0;
            dvsr      <= '0;
            rem       <= '0;
            count     <= '0;
            is_rem    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            pend_prf  <= '0;
            pend_rob  <= '0;
            pend_pc   <= '0;
            out_value <= '0;
            out_prf   <= '0;
            out_rob   <= '0;
            out_pc    <= '0;
        end else if (bus.squash) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (issue && fast) begin
                        state     <= DONE;
                        out_value <= fast_value;
                        out_prf   <= bus.dest_preg_idx;
                        out_rob   <= bus.rob_idx;
                        out_pc    <= bus.PC;
                    end else if (issue) begin
                        state    <= BUSY;
                        quo      <= a_mag;
                        dvsr     <= b_mag;
                        rem      <= '0;
                        count    <= CNT_W'(XLEN-1);
                        is_rem   <= bus.div_func[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        pend_prf <= bus.dest_preg_idx;
                        pend_rob <= bus.rob_idx;
                        pend_pc  <= bus.PC;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    quo   <= quo_next;
                    rem   <= rem_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state     <= DONE;
                        out_value <= final_value;
                        out_prf   <= pend_prf;
                        out_rob   <= pend_rob;
                        out_pc    <= pend_pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.div_valid   = (state == DONE);
    assign bus.div_free    = free;
    assign bus.div_value   = out_value;
    assign bus.div_prf_idx = out_prf;
    assign bus.div_rob_idx = out_rob;
    assign bus.div_PC      = out_pc;
endmodule

// File: tb/tb_div2cdb.sv
// tb/tb_div2cdb.sv - scoreboard bench for the div2cdb divider FU
module tb_div2cdb;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [31:0] value;
        logic [5:0]  prf;
        logic [4:0]  rob;
        logic [31:0] pc;
        int          due;
    } exp_t;

    exp_t sb[$];

    div2cdb_if bus ();

    div2cdb dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic is_fast(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sb_;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'd0 : 32'h8000_0000;
        sa = a;
        sb_ = b;
        case (f)
            2'b00:   return 32'(sa / sb_);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb_);
            default: return a % b;
        endcase
    endfunction

    // Scoreboard checker: every valid result must match the oldest expected entry
    always @(negedge clock) begin
        if (!reset && bus.div_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid cycle %0d value %h, required no result", cyc, bus.div_value);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.div_value !== e.value) begin
                    miscompares++;
                    $display("FAIL result_value got %h required %h", bus.div_value, e.value);
                end
                vectors++;
                if ({bus.div_prf_idx, bus.div_rob_idx, bus.div_PC} !== {e.prf, e.rob, e.pc}) begin
                    miscompares++;
                    $display("FAIL result_tags got %h/%h/%h required %h/%h/%h",
                             bus.div_prf_idx, bus.div_rob_idx, bus.div_PC, e.prf, e.rob, e.pc);
                end
                vectors++;
                if (cyc !== e.due) begin
                    miscompares++;
                    $display("FAIL result_cycle got %0d required %0d", cyc, e.due);
                end
            end
        end
    end

    // Called at a negedge; drives one issue pulse and optionally records the expected result
    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] prf, input logic [4:0] rob, input logic [31:0] pc,
                         input logic push);
        exp_t e;
        bus.div_enable    = 1'b1;
        bus.div_func      = f;
        bus.opa_value     = a;
        bus.opb_value     = b;
        bus.dest_preg_idx = prf;
        bus.rob_idx       = rob;
        bus.PC            = pc;
        if (push) begin
            e.value = model(f, a, b);
            e.prf   = prf;
            e.rob   = rob;
            e.pc    = pc;
            e.due   = cyc + (is_fast(f, a, b) ? 1 : 33);
            sb.push_back(e);
        end
        @(posedge clock);
        #1 bus.div_enable = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout pending %0d required 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        vectors++;
        if ({bus.div_valid, bus.div_free} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_flags got valid=%b free=%b required valid=0 free=1", bus.div_valid, bus.div_free);
        end
        vectors++;
        if ({bus.div_value, bus.div_prf_idx, bus.div_rob_idx, bus.div_PC} !== 75'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h/%h/%h/%h required all zero",
                     bus.div_value, bus.div_prf_idx, bus.div_rob_idx, bus.div_PC);
        end
    endtask

    task automatic test_unsigned();
        issue(2'b01, 32'd100, 32'd7, 6'd11, 5'd3, 32'h0000_1000, 1'b1);
        @(negedge clock);
        vectors++;
        if (bus.div_free !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_free got %b required 0", bus.div_free);
        end
        wait_drain();
        issue(2'b11, 32'd100, 32'd7, 6'd12, 5'd4, 32'h0000_1004, 1'b1);
        wait_drain();
    endtask

    task automatic test_signed();
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 6'd1, 5'd1, 32'h10, 1'b1);
        wait_drain();
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 6'd2, 5'd2, 32'h14, 1'b1);
        wait_drain();
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, 6'd3, 5'd3, 32'h18, 1'b1);
        wait_drain();
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 6'd4, 5'd4, 32'h1C, 1'b1);
        wait_drain();
    endtask

    task automatic test_fast_path();
        issue(2'b00, 32'd5, 32'd0, 6'd5, 5'd5, 32'h20, 1'b1);
        @(negedge clock);
        vectors++;
        if (bus.div_free !== 1'b1) begin
            miscompares++;
            $display("FAIL fast_free got %b required 1", bus.div_free);
        end
        wait_drain();
        issue(2'b11, 32'd5, 32'd0, 6'd6, 5'd6, 32'h24, 1'b1);
        wait_drain();
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd7, 5'd7, 32'h28, 1'b1);
        wait_drain();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd8, 5'd8, 32'h2C, 1'b1);
        wait_drain();
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 6'd9, 5'd9, 32'h30, 1'b1);
        wait_drain();
    endtask

    task automatic test_squash();
        int c0 = cyc;
        int n = 0;
        issue(2'b01, 32'd9, 32'd3, 6'd20, 5'd20, 32'h40, 1'b0);
        while (cyc != c0 + 10 && n < 20) begin
            @(negedge clock);
            n++;
        end
        bus.squash = 1'b1;
        @(posedge clock);
        #1 bus.squash = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus.div_free !== 1'b1 || cyc !== c0 + 11) begin
            miscompares++;
            $display("FAIL squash_free got free=%b cycle=%0d required free=1 cycle=%0d", bus.div_free, cyc, c0 + 11);
        end
        repeat (30) @(negedge clock);
        bus.squash = 1'b1;
        issue(2'b01, 32'd50, 32'd5, 6'd21, 5'd21, 32'h44, 1'b0);
        bus.squash = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus.div_free !== 1'b1) begin
            miscompares++;
            $display("FAIL squash_drop got free=%b required 1", bus.div_free);
        end
        issue(2'b01, 32'd8, 32'd2, 6'd22, 5'd22, 32'h48, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        issue(2'b01, 32'd1000, 32'd9, 6'd30, 5'd10, 32'h50, 1'b1);
        while (!bus.div_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        issue(2'b11, 32'd1000, 32'd9, 6'd31, 5'd11, 32'h54, 1'b1);
        @(negedge clock);
        vectors++;
        if (bus.div_valid !== 1'b0 || bus.div_free !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_after_done got valid=%b free=%b required valid=0 free=0", bus.div_valid, bus.div_free);
        end
        wait_drain();
    endtask

    task automatic test_busy_ignore();
        issue(2'b00, 32'hFFFF_FC18, 32'd7, 6'd40, 5'd12, 32'h60, 1'b1);
        repeat (4) @(negedge clock);
        issue(2'b01, 32'd1, 32'd0, 6'd41, 5'd13, 32'h64, 1'b0);
        @(negedge clock);
        issue(2'b11, 32'hDEAD_BEEF, 32'd3, 6'd42, 5'd14, 32'h68, 1'b0);
        repeat (8) @(negedge clock);
        issue(2'b10, 32'd77, 32'd5, 6'd43, 5'd15, 32'h6C, 1'b0);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int c0 = cyc;
        int n = 0;
        issue(2'b01, 32'd123, 32'd4, 6'd50, 5'd16, 32'h70, 1'b0);
        while (cyc != c0 + 20 && n < 30) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus.div_free !== 1'b1 || bus.div_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got free=%b valid=%b required free=1 valid=0", bus.div_free, bus.div_valid);
        end
        repeat (40) @(negedge clock);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [1:0]  f;
            logic [31:0] a, b;
            f = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i == 4) b = 32'd0;
            if (i == 7) b = 32'hFFFF_FFFF;
            issue(f, a, b, 6'(i), 5'(i + 1), 32'h100 + 32'(i * 4), 1'b1);
            wait_drain();
        end
    endtask

    initial begin
        bus.div_enable    = 1'b0;
        bus.squash        = 1'b0;
        bus.opa_value     = '0;
        bus.opb_value     = '0;
        bus.div_func      = '0;
        bus.dest_preg_idx = '0;
        bus.rob_idx       = '0;
        bus.PC            = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_fast_path();
        test_squash();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got %0d required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
